// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Optional saturation is enabled with the ADDSUB_SAT_EN macro.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  localparam int SAT_MAX_W = 256;

  // Signed min (sign = 1) or signed max (sign = 0) for a 'width'-bit value,
  // returned zero-extended; the caller keeps the low 'width' bits.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int unsigned width);
    logic [SAT_MAX_W-1:0] msb;
    msb = '0;
    msb[width-1] = 1'b1;
    return sign ? msb : (msb - SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The sat signal exists only when ADDSUB_SAT_EN is defined.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             v;
  logic             n;
  logic             z;

  modport slave (
    input  in_valid, op_sub, c_in, a, b, out_ready,
`ifdef ADDSUB_SAT_EN
    input  sat,
`endif
    output in_ready, out_valid, result, c_out, v, n, z
  );

  modport master (
    output in_valid, op_sub, c_in, a, b, out_ready,
`ifdef ADDSUB_SAT_EN
    output sat,
`endif
    input  in_ready, out_valid, result, c_out, v, n, z
  );

endinterface

// File: rtl/addsub_slice.sv
// Registered SW-bit adder slice with hold enable; also registers the carry
// into its MSB so the topmost slice can produce the overflow flag.
module addsub_slice #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum_q,
  output logic          cout_q,
  output logic          cmsb_q
);

  logic [SW:0]   full_d;
  logic [SW-1:0] sum_d;
  logic          cout_d;
  logic          cmsb_d;

  always_comb begin
    full_d = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    sum_d  = full_d[SW-1:0];
    cout_d = full_d[SW];
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    cmsb_d = a[SW-1] ^ b[SW-1] ^ sum_d[SW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      cmsb_q <= 1'b0;
    end else if (en) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      cmsb_q <= cmsb_d;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered
// slices behind a global-stall valid/ready pipeline. ADDSUB_SAT_EN adds clamping.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         reset,
  addsub_pipe_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  logic             advance;
  logic             out_valid;
  logic [WIDTH-1:0] bx_in;
  logic             cin_in;
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] res;
  logic             v_raw;
  logic [3:0]       flags;

  always_comb begin
    bx_in  = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
    cin_in = (bus.op_sub == OP_SUB) ? ~bus.c_in : bus.c_in;
  end

  // Stage k register x_q: finished result bits of slices 0..k-1 (low),
  // then pending A bits and pending B' bits above slice k.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = k * SW;
    localparam int PW = (STAGES - 1 - k) * SW;
    localparam int XW = (RW + 2 * PW > 0) ? (RW + 2 * PW) : 1;

    logic          vld_in;
    logic          vld_d;
    logic          vld_q;
    logic          en;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic          sc;
    logic [SW-1:0] sum_q;
    logic          cout_q;
    logic          cmsb_q;
    logic [XW-1:0] x_d;
    logic [XW-1:0] x_q;
`ifdef ADDSUB_SAT_EN
    logic          sat_d;
    logic          sat_q;
`endif

    if (k == 0) begin : g_head
      always_comb begin
        vld_in = bus.in_valid;
        sa     = bus.a[SW-1:0];
        sb     = bx_in[SW-1:0];
        sc     = cin_in;
`ifdef ADDSUB_SAT_EN
        sat_d  = bus.sat;
`endif
        x_d = '0;
        for (int i = 0; i < PW; i++) begin
          x_d[i]      = bus.a[SW+i];
          x_d[PW+i]   = bx_in[SW+i];
        end
      end
    end else begin : g_body
      localparam int PRW = (k - 1) * SW;
      localparam int PPW = (STAGES - k) * SW;
      always_comb begin
        vld_in = g_st[k-1].vld_q;
        sa     = g_st[k-1].x_q[PRW +: SW];
        sb     = g_st[k-1].x_q[PRW+PPW +: SW];
        sc     = g_st[k-1].cout_q;
`ifdef ADDSUB_SAT_EN
        sat_d  = g_st[k-1].sat_q;
`endif
        x_d = '0;
        for (int i = 0; i < PRW; i++) x_d[i] = g_st[k-1].x_q[i];
        for (int i = 0; i < SW; i++) x_d[PRW+i] = g_st[k-1].sum_q[i];
        for (int i = 0; i < PW; i++) begin
          x_d[RW+i]    = g_st[k-1].x_q[PRW+SW+i];
          x_d[RW+PW+i] = g_st[k-1].x_q[PRW+PPW+SW+i];
        end
      end
    end

    always_comb begin
      en    = advance & vld_in;
      vld_d = advance ? vld_in : vld_q;
    end

    always_ff @(posedge clk) begin
      if (reset) vld_q <= 1'b0;
      else       vld_q <= vld_d;
    end

    // Only the last stage feeds the outputs, so only it needs a data reset.
    always_ff @(posedge clk) begin
      if (reset && (k == STAGES - 1)) x_q <= '0;
      else if (en)                    x_q <= x_d;
    end

`ifdef ADDSUB_SAT_EN
    always_ff @(posedge clk) begin
      if (reset && (k == STAGES - 1)) sat_q <= 1'b0;
      else if (en)                    sat_q <= sat_d;
    end
`endif

    addsub_slice #(.SW(SW)) u_slice (
      .clk    (clk),
      .rst    ((k == STAGES - 1) && reset),
      .en     (en),
      .a      (sa),
      .b      (sb),
      .cin    (sc),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .cmsb_q (cmsb_q)
    );
  end

  if (STAGES == 1) begin : g_res_one
    always_comb raw_res = g_st[0].sum_q;
  end else begin : g_res_many
    always_comb raw_res = {g_st[STAGES-1].sum_q, g_st[STAGES-1].x_q};
  end

  always_comb begin
    out_valid = g_st[STAGES-1].vld_q;
    advance   = ~out_valid | bus.out_ready;
    v_raw     = g_st[STAGES-1].cout_q ^ g_st[STAGES-1].cmsb_q;
  end

`ifdef ADDSUB_SAT_EN
  logic [SAT_MAX_W-1:0] sat_full;
  // On overflow the true sign is the opposite of the wrapped MSB.
  always_comb begin
    sat_full = sat_value(~raw_res[WIDTH-1], WIDTH);
    res      = (g_st[STAGES-1].sat_q & v_raw) ? sat_full[WIDTH-1:0] : raw_res;
  end
`else
  always_comb res = raw_res;
`endif

  always_comb begin
    flags         = '0;
    flags[FLAG_C] = g_st[STAGES-1].cout_q;
    flags[FLAG_V] = v_raw;
    flags[FLAG_N] = res[WIDTH-1];
    flags[FLAG_Z] = (res == '0);
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid;
  assign bus.result    = res;
  assign bus.c_out     = flags[FLAG_C];
  assign bus.v         = flags[FLAG_V];
  assign bus.n         = flags[FLAG_N];
  assign bus.z         = flags[FLAG_Z];

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit with carry/borrow-in and full flag output (C, V, N, Z).
- Next generation of the team's 32-bit combinational subtractor. Width is generic, the carry chain is split into registered slices, and a valid/ready handshake is added.
- Sits between the operand-select logic and the writeback/branch-compare path of the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices; each slice handles WIDTH/STAGES bits; range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- op_sub  input  1  0 = add, 1 = subtract
- c_in  input  1  carry-in (add) / borrow-in (sub)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference
- c_out  output  1  carry-out; for sub, 1 = no borrow
- v  output  1  signed overflow
- n  output  1  result[WIDTH-1]
- z  output  1  result == 0

Behaviour:
- Arithmetic per beat: effective B' = op_sub ? ~b : b; adder carry-in = op_sub ? ~c_in : c_in.
  - Add: result = a + b + c_in.
  - Sub: result = a - b - c_in.
  - c_out = carry out of bit WIDTH-1 of a + B' + cin.
  - v = carry into MSB XOR carry out of MSB.
- Slicing:
  - Stage k computes bits [k*W/S +: W/S] using the carry registered by stage k-1.
  - Upper operand bits and already-finished lower result bits are skewed/carried in stage registers.
  - No combinational path spans more than one slice.
- Latency: exactly STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, when not stalled. Throughput is 1 beat/cycle.
- Flow control: global stall.
  - advance = ~out_valid | out_ready; in_ready = advance.
  - When advance = 0, every stage register, including valids, holds.
  - Bubbles are not compressed.
- Output stability: while out_valid & ~out_ready, result/c_out/v/n/z are held stable.
- Flag registration: n and z are derived from the final registered result. c_out and v are registered with it in the last stage.
- Reset:
  - All stage valid bits clear; out_valid = 0; result = 0; c_out = v = n = 0; z = 1.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight beats; no partial result is ever emitted.
- Boundaries:
  - STAGES = 1 degenerates to a single registered adder with latency 1.
  - Accept and emit in the same cycle is legal when out_ready = 1.
  - Data inputs are ignored when in_valid = 0; stage valid stays 0.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: adds input port sat (1 bit), carried down the pipeline with the beat. If sat = 1 and v = 1, result clamps to signed max (0x7FFF_FFFF for WIDTH=32) when the true result is positive, or signed min (0x8000_0000) when negative. v still reports 1; c_out is unchanged; n and z follow the clamped result.
- Undefined: no sat port; result always wraps modulo 2^WIDTH.

Decomposition:
- Package addsub_pkg:
  - localparams OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Flag bit indices FLAG_C=0, FLAG_V=1, FLAG_N=2, FLAG_Z=3.
  - Function sat_value(sign, WIDTH).
- Sub-module addsub_slice (parameter SW = slice width):
  - Registered SW-bit adder slice with carry-in/carry-out and hold enable.
  - Also exposes the carry into its MSB so the top slice can derive v.
  - Instantiated STAGES times via generate.

Test Plan (WIDTH=32, STAGES=4, out_ready=1 unless stated):
- Sub, c_in=0, a=2, b=1 -> after 4 cycles result=0x00000001, c_out=1, v=0, n=0, z=0.
- Sub, c_in=0, a=1, b=2 -> result=0xFFFFFFFF, c_out=0, n=1, v=0; then a=1, b=1 -> result=0, z=1, c_out=1.
- Sub, c_in=1, a=0x80000001, b=1 -> result=0x7FFFFFFF, v=1, c_out=1. Add, c_in=0, a=0x7FFFFFFF, b=1 -> result=0x80000000, v=1, c_out=0; with ADDSUB_SAT_EN and sat=1 -> result=0x7FFFFFFF.
- Add, c_in=1, a=0xFFFFFFFF, b=0 -> result=0, c_out=1, z=1 (carry ripples across all 4 slices).
- Stream 8 back-to-back beats; drop out_ready for 3 cycles mid-stream -> in_ready=0 exactly while out_valid & ~out_ready; all 8 results emitted in order, none duplicated or lost, and outputs held stable during the stall.
- Assert reset with 3 beats in flight -> no out_valid afterwards; first beat after reset returns a correct result 4 cycles after acceptance.
